// File: rtl/cpu_single_cycle_pkg.sv
// Shared constants and types for the single-cycle MIPS core: opcodes, funct
// codes, memory geometry and the decoded control bundle.
package cpu_single_cycle_pkg;

  localparam int WORD_W  = 32;
  localparam int MEM_DEPTH = 256;
  localparam int MEM_AW  = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef struct packed {
    logic    reg_we;
    logic    reg_dst_rd;
    logic    alu_src_imm;
    logic    mem_we;
    logic    mem_to_reg;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_single_cycle_word_memory.sv
// Word-wide memory with asynchronous read and a synchronous, enabled write.
// Used both as instruction ROM (write tied off) and as data RAM.
module word_memory
  import cpu_single_cycle_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] memory [0:MEM_DEPTH-1];

  // Read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign rdata = memory[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      memory[addr] <= wdata;
    end
  end

endmodule

// File: rtl/cpu_single_cycle.sv
// Single-cycle MIPS subset core: fetch, decode, execute, memory and writeback
// all complete in one clk cycle. Memories are not cleared by reset.
module cpu_single_cycle
  import cpu_single_cycle_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] sext_imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] dm_rdata;
  logic [31:0] wr_data;
  logic [4:0]  wr_reg;
  logic        mem_we;
  logic        rs_eq_rt;
  logic        take_branch;
  ctrl_t       ctrl;

  logic [31:0] rf [0:31];

  // PC lives in a named scope so it can be probed as b2v_PC.Q.
  if (1) begin : b2v_PC
    logic [31:0] Q;
    always_ff @(posedge clk) begin
      if (rst) begin
        Q <= '0;
      end else begin
        Q <= next_pc;
      end
    end
  end

  assign pc = b2v_PC.Q;

  word_memory b2v_im (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[9:2]),
    .wdata ('0),
    .rdata (instr)
  );

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign sext_imm = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst_rd = 1'b1;
        unique case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_we      = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_we      = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_we      = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_BEQ:  ctrl.branch_eq = 1'b1;
      OP_BNE:  ctrl.branch_ne = 1'b1;
      OP_J:    ctrl.jump      = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Register 0 is hardwired: reads return zero regardless of array contents.
  assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf[rt];
  assign alu_b  = ctrl.alu_src_imm ? sext_imm : rt_val;

  always_comb begin
    alu_y = '0;
    unique case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign mem_we = ctrl.mem_we & ~rst;

  word_memory b2v_dm (
    .clk   (clk),
    .we    (mem_we),
    .addr  (alu_y[9:2]),
    .wdata (rt_val),
    .rdata (dm_rdata)
  );

  assign wr_reg  = ctrl.reg_dst_rd ? rd : rt;
  assign wr_data = ctrl.mem_to_reg ? dm_rdata : alu_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (ctrl.reg_we && (wr_reg != 5'd0)) begin
      rf[wr_reg] <= wr_data;
    end
  end

  assign pc_plus4    = pc + 32'd4;
  assign rs_eq_rt    = (rs_val == rt_val);
  assign take_branch = (ctrl.branch_eq & rs_eq_rt) | (ctrl.branch_ne & ~rs_eq_rt);

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + {sext_imm[29:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_cpu_single_cycle.sv
// Directed bench for cpu_single_cycle: a table of single-instruction steps,
// a branch/jump walk, and bubble sort with a mid-run reset.
module tb_cpu_single_cycle;

  logic clk_tb;
  logic rst;

  int n_checks;
  int n_fail;

  cpu_single_cycle dut (
    .clk (clk_tb),
    .rst (rst)
  );

  // Clock/reset block
  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic [4:0]  chk_reg;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [19];
  logic [31:0] br_prog_pc [10];
  logic [31:0] snap [12];

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Scoreboard
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk_tb);
    @(negedge clk_tb);
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      dut.b2v_im.memory[i] = 32'h0;
      dut.b2v_dm.memory[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_tb);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to_pc(logic [31:0] target, int budget);
    int cyc;
    cyc = 0;
    while (dut.b2v_PC.Q !== target && cyc < budget) begin
      step();
      cyc++;
    end
    check("reach_pc", dut.b2v_PC.Q, target);
  endtask

  task automatic load_sort_data();
    dut.b2v_dm.memory[128] = 32'd55;
    dut.b2v_dm.memory[129] = 32'd88;
    dut.b2v_dm.memory[130] = 32'd0;
    dut.b2v_dm.memory[131] = 32'd22;
    dut.b2v_dm.memory[132] = 32'd77;
    dut.b2v_dm.memory[133] = 32'd11;
    dut.b2v_dm.memory[134] = 32'd99;
    dut.b2v_dm.memory[135] = 32'd33;
    dut.b2v_dm.memory[136] = 32'd110;
    dut.b2v_dm.memory[137] = 32'd66;
    dut.b2v_dm.memory[138] = 32'd121;
    dut.b2v_dm.memory[139] = 32'd44;
  endtask

  task automatic load_sort_prog();
    dut.b2v_im.memory[0]  = enc_i(6'h08, 0, 16, 16'h0200);
    dut.b2v_im.memory[1]  = enc_i(6'h08, 0, 17, 16'd12);
    dut.b2v_im.memory[2]  = enc_i(6'h08, 17, 18, 16'hFFFF);
    dut.b2v_im.memory[3]  = enc_i(6'h08, 0, 19, 16'd0);
    dut.b2v_im.memory[4]  = enc_r(19, 18, 8, 6'h2A);
    dut.b2v_im.memory[5]  = enc_i(6'h08, 0, 9, 16'd0);
    dut.b2v_im.memory[6]  = enc_i(6'h08, 0, 11, 16'd0);
    dut.b2v_im.memory[7]  = enc_i(6'h04, 8, 0, 16'd17);
    dut.b2v_im.memory[8]  = enc_r(0, 0, 24, 6'h20);
    dut.b2v_im.memory[9]  = enc_r(9, 18, 12, 6'h2A);
    dut.b2v_im.memory[10] = enc_i(6'h04, 12, 0, 16'd12);
    dut.b2v_im.memory[11] = enc_r(9, 9, 24, 6'h20);
    dut.b2v_im.memory[12] = enc_r(24, 24, 24, 6'h20);
    dut.b2v_im.memory[13] = enc_r(16, 24, 10, 6'h20);
    dut.b2v_im.memory[14] = enc_i(6'h23, 10, 13, 16'd0);
    dut.b2v_im.memory[15] = enc_i(6'h23, 10, 14, 16'd4);
    dut.b2v_im.memory[16] = enc_r(14, 13, 15, 6'h2A);
    dut.b2v_im.memory[17] = enc_i(6'h04, 15, 0, 16'd2);
    dut.b2v_im.memory[18] = enc_i(6'h2B, 10, 14, 16'd0);
    dut.b2v_im.memory[19] = enc_i(6'h2B, 10, 13, 16'd4);
    dut.b2v_im.memory[20] = enc_i(6'h08, 9, 9, 16'd1);
    dut.b2v_im.memory[21] = enc_r(11, 15, 11, 6'h20);
    dut.b2v_im.memory[22] = enc_j(26'd9);
    dut.b2v_im.memory[23] = enc_i(6'h08, 19, 19, 16'd1);
    dut.b2v_im.memory[24] = enc_j(26'd4);
  endtask

  task automatic check_sorted(string tag);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("%s_dm%0d", tag, 128 + k), dut.b2v_dm.memory[128 + k], 32'(11 * k));
    end
  endtask

  initial begin
    logic [31:0] any_reg;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    vecs[0]  = '{"addi_pos",    enc_i(6'h08, 0, 17, 16'd12),       32'd4,  5'd17, 32'd12};
    vecs[1]  = '{"addi_neg",    enc_i(6'h08, 17, 18, 16'hFFFF),    32'd8,  5'd18, 32'd11};
    vecs[2]  = '{"addi_ffff",   enc_i(6'h08, 0, 8, 16'hFFFF),      32'd12, 5'd8,  32'hFFFF_FFFF};
    vecs[3]  = '{"addi_zero",   enc_i(6'h08, 0, 0, 16'd5),         32'd16, 5'd0,  32'd0};
    vecs[4]  = '{"addi_base",   enc_i(6'h08, 0, 11, 16'h0200),     32'd20, 5'd11, 32'd512};
    vecs[5]  = '{"addi_s5",     enc_i(6'h08, 0, 21, 16'h8765),     32'd24, 5'd21, 32'hFFFF_8765};
    vecs[6]  = '{"sw_noreg",    enc_i(6'h2B, 11, 21, 16'd0),       32'd28, 5'd21, 32'hFFFF_8765};
    vecs[7]  = '{"lw_back",     enc_i(6'h23, 11, 20, 16'd0),       32'd32, 5'd20, 32'hFFFF_8765};
    vecs[8]  = '{"add",         enc_r(17, 18, 9, 6'h20),           32'd36, 5'd9,  32'd23};
    vecs[9]  = '{"sub_wrap",    enc_r(18, 17, 10, 6'h22),          32'd40, 5'd10, 32'hFFFF_FFFF};
    vecs[10] = '{"and",         enc_r(8, 17, 12, 6'h24),           32'd44, 5'd12, 32'd12};
    vecs[11] = '{"or",          enc_r(17, 18, 13, 6'h25),          32'd48, 5'd13, 32'd15};
    vecs[12] = '{"slt_signed",  enc_r(10, 17, 14, 6'h2A),          32'd52, 5'd14, 32'd1};
    vecs[13] = '{"slt_false",   enc_r(17, 10, 15, 6'h2A),          32'd56, 5'd15, 32'd0};
    vecs[14] = '{"add_wrap",    enc_r(8, 8, 24, 6'h20),            32'd60, 5'd24, 32'hFFFF_FFFE};
    vecs[15] = '{"bad_funct",   enc_r(17, 18, 24, 6'h00),          32'd64, 5'd24, 32'hFFFF_FFFE};
    vecs[16] = '{"bad_opcode",  enc_i(6'h3F, 17, 24, 16'd1),       32'd68, 5'd24, 32'hFFFF_FFFE};
    vecs[17] = '{"lw_alias",    enc_i(6'h23, 11, 25, 16'h0402),    32'd72, 5'd25, 32'hFFFF_8765};
    vecs[18] = '{"rw_same_reg", enc_r(17, 17, 17, 6'h20),          32'd76, 5'd17, 32'd24};

    br_prog_pc = '{32'd28, 32'd100, 32'd88, 32'd36, 32'd40, 32'd4, 32'd8, 32'd28, 32'd32, 32'd0};

    // Table-driven single-instruction steps
    clear_mems();
    for (int i = 0; i < 19; i++) dut.b2v_im.memory[i] = vecs[i].instr;
    do_reset();
    check("reset_pc", dut.b2v_PC.Q, 32'd0);
    for (int i = 0; i < 19; i++) begin
      step();
      check({vecs[i].name, "_pc"}, dut.b2v_PC.Q, vecs[i].exp_pc);
      check(vecs[i].name, (vecs[i].chk_reg == 5'd0) ? 32'd0 : dut.rf[vecs[i].chk_reg],
            vecs[i].exp_val);
    end
    check("sw_dm128", dut.b2v_dm.memory[128], 32'hFFFF_8765);

    // Branch / jump walk
    clear_mems();
    dut.b2v_im.memory[0]  = enc_j(26'd7);
    dut.b2v_im.memory[7]  = enc_i(6'h04, 8, 0, 16'd17);
    dut.b2v_im.memory[25] = enc_j(26'd22);
    dut.b2v_im.memory[22] = enc_j(26'd9);
    dut.b2v_im.memory[9]  = enc_i(6'h05, 0, 0, 16'd5);
    dut.b2v_im.memory[10] = enc_i(6'h04, 0, 0, 16'hFFF6);
    dut.b2v_im.memory[1]  = enc_i(6'h08, 0, 8, 16'd1);
    dut.b2v_im.memory[2]  = enc_j(26'd7);
    dut.b2v_im.memory[8]  = enc_i(6'h05, 8, 0, 16'hFFF7);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("branch_step%0d", i), dut.b2v_PC.Q, br_prog_pc[i]);
    end

    // Bubble sort, full run
    clear_mems();
    load_sort_prog();
    load_sort_data();
    do_reset();
    run_to_pc(32'd100, 5000);
    check_sorted("sort1");

    // Bubble sort with reset asserted mid-run, then rerun
    load_sort_data();
    do_reset();
    for (int i = 0; i < 400; i++) step();
    for (int k = 0; k < 12; k++) snap[k] = dut.b2v_dm.memory[128 + k];
    rst = 1'b1;
    step();
    check("midreset_pc", dut.b2v_PC.Q, 32'd0);
    any_reg = 32'd0;
    for (int r = 0; r < 32; r++) any_reg = any_reg | dut.rf[r];
    check("midreset_regs", any_reg, 32'd0);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("midreset_dm%0d", 128 + k), dut.b2v_dm.memory[128 + k], snap[k]);
    end
    check("midreset_im0", dut.b2v_im.memory[0], enc_i(6'h08, 0, 16, 16'h0200));
    rst = 1'b0;
    step();
    check("restart_pc", dut.b2v_PC.Q, 32'd4);
    run_to_pc(32'd100, 5000);
    check_sorted("sort2");

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_single_cycle.md
CPU_SINGLE_CYCLE -- requirements
Module: cpu_single_cycle

Interface
REQ-001 Parameters: none; all memory sizes fixed in the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Port order SHALL be clk, rst; no other ports.

Function
REQ-005 SHALL execute one 32-bit MIPS instruction per clk cycle: fetch, decode, execute, memory access and writeback all complete within the cycle.
REQ-006 PC SHALL be a 32-bit register and reset to 0.
- Next PC defaults to PC+4.
REQ-007 Instruction fetch SHALL read instruction memory word PC[9:2] combinationally; instruction memory SHALL hold 256 words and SHALL be read-only to the core.
REQ-008 Register file SHALL have 32x32 bits.
- Two combinational read ports; one write port, written on the rising edge.
- Register 0 SHALL always read 0; writes to it are discarded.
REQ-009 R-type (opcode 0x00): rd <= f(rs, rt) for these funct codes:
- add 0x20, sub 0x22, and 0x24, or 0x25.
- slt 0x2A: signed compare, result 1 or 0.
- Arithmetic SHALL wrap modulo 2^32; there is no overflow trap.
REQ-010 addi (0x08): rt <= rs + sign-extended imm16.
REQ-011 lw (0x23): rt <= DM[(rs+sext(imm))[9:2]]; the data memory read SHALL be combinational.
REQ-012 sw (0x2B): DM[(rs+sext(imm))[9:2]] <= rt on the rising edge; no register write.
REQ-013 beq (0x04): if rs==rt, PC <= PC+4+(sext(imm)<<2); otherwise PC+4.
REQ-014 bne (0x05): same as beq with the condition inverted.
REQ-015 j (0x02): PC <= {PC+4[31:28], target26, 2'b00}.
REQ-016 Any other opcode or funct SHALL act as a no-op: no register or memory write, PC+4.
REQ-017 Data memory SHALL hold 256 words, byte-addressed with word granularity; address bits [1:0] are ignored.
REQ-018 Address wrap: addresses beyond 1 KiB SHALL alias modulo 1 KiB in both memories.
REQ-019 Simultaneous read and write of the same register or memory word: the read returns the old value within the cycle, and the write lands at the edge.

Reset
REQ-020 While rst is high at a rising edge:
- PC <= 0.
- All 32 registers <= 0.
- No memory write occurs.
REQ-021 Reset SHALL NOT clear instruction or data memory contents, so preloaded programs and data survive reset.
REQ-022 Reset asserted mid-program SHALL restart execution at PC 0 on the first edge after deassertion.

Structure
REQ-023 A shared package SHALL hold:
- opcode constants (0x00, 0x02, 0x04, 0x05, 0x08, 0x23, 0x2B);
- funct constants (0x20, 0x22, 0x24, 0x25, 0x2A);
- memory depth (256) and word width (32).
REQ-024 Instance and signal names SHALL be as follows, because benches probe them hierarchically:
- instruction memory instance b2v_im, with array memory[0:255];
- data memory instance b2v_dm, with array memory[0:255];
- PC register instance b2v_PC, with output Q.
REQ-025 One reusable sub-module, word_memory (32x256, asynchronous read, synchronous write enable), SHALL be instantiated for both b2v_im (write disabled) and b2v_dm.
REQ-026 The PC register, register file, ALU and control decode SHALL stay inside the top module.

Verification
REQ-027 Bubble sort:
- Stimulus: load the 25-word bubble-sort program (addi/slt/beq/add/lw/sw/j) at IM[0..24], and data 55,88,0,22,77,11,99,33,110,66,121,44 at byte 512..556.
- Required response: when PC reaches 100, DM words 128..139 are strictly ascending (0,11,22,...,121).
REQ-028 addi sign extension:
- Stimulus: addi $s2,$s1,-1 with $s1=12.
- Required response: $s2 = 11.
- Also: addi $t0,$zero,0xFFFF gives $t0 = 0xFFFFFFFF.
REQ-029 Branch and jump:
- beq taken at PC 28 with imm=17 gives next PC 100.
- beq not taken gives PC 32.
- j 9 at PC 88 gives PC 36.
REQ-030 Memory round trip and $zero:
- sw $s5,0($t3) then lw $s4,0($t3) with $t3=512 returns the stored value.
- addi $zero,$zero,5 leaves $zero = 0.
REQ-031 Reset:
- Stimulus: assert rst for one edge mid-run, then rerun.
- Required response: PC = 0 and registers = 0; DM is unchanged; the program reruns to the same result.
